// File: rtl/sobel_packer_if.sv
// Pixel-in / packed-word-out bundle for sobel_packer; the slave side is the
// packer itself and the master side is whatever drives and drains it.
interface sobel_packer_if;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [63:0] data_out;
  logic [7:0]  keep_out;
  logic        last_out;
  logic        valid_out;
  logic        ready_in;
  logic        overflow;

  modport slave (
    input  data_in, valid_in, ready_in,
    output data_out, keep_out, last_out, valid_out, overflow
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  data_out, keep_out, last_out, valid_out, overflow
  );
endinterface

// File: rtl/sobel_packer.sv
// Packs 8-bit edge pixels into 64-bit words behind a 2-entry output FIFO.
// Define SOBEL_PACKER_BIN_EN to binarize pixels against THRESHOLD before packing.
module sobel_packer #(
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter logic [7:0]  THRESHOLD    = 8'd64
) (
  input logic            clk,
  input logic            rst,
  sobel_packer_if.slave  bus
);

`ifdef SOBEL_PACKER_BIN_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  localparam logic [23:0] LAST_PIX = 24'(FRAME_PIXELS - 1);

  logic [63:0] asm_data;
  logic [2:0]  byte_idx;
  logic [23:0] pix_cnt;

  logic [63:0] fifo_data [2];
  logic [7:0]  fifo_keep [2];
  logic        fifo_last [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fifo_cnt;
  logic        overflow_r;

  logic [7:0]  bin_val;
  logic [7:0]  pix_val;
  logic [63:0] word_data;
  logic [7:0]  word_keep;
  logic        frame_end;
  logic        word_done;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;

  // Bytes above byte_idx in asm_data are always zero, so OR-ing the new pixel
  // in yields the finished word with its unwritten bytes already cleared.
  always_comb begin
    bin_val    = (bus.data_in >= THRESHOLD) ? 8'hFF : 8'h00;
    pix_val    = BIN_EN ? bin_val : bus.data_in;
    word_data  = asm_data | ({56'd0, pix_val} << {byte_idx, 3'b000});
    word_keep  = 8'hFF >> (3'd7 - byte_idx);
    frame_end  = (pix_cnt == LAST_PIX);
    word_done  = bus.valid_in && ((byte_idx == 3'd7) || frame_end);
    fifo_empty = (fifo_cnt == 2'd0);
    fifo_full  = (fifo_cnt == 2'd2);
    do_pop     = !fifo_empty && bus.ready_in;
    do_push    = word_done && (!fifo_full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_data <= '0;
      byte_idx <= '0;
      pix_cnt  <= '0;
    end else if (bus.valid_in) begin
      if (word_done) begin
        asm_data <= '0;
        byte_idx <= '0;
      end else begin
        asm_data <= word_data;
        byte_idx <= byte_idx + 3'd1;
      end
      pix_cnt <= frame_end ? 24'd0 : pix_cnt + 24'd1;
    end
  end

  // When full with a pop, wr_ptr equals rd_ptr: the head is overwritten only
  // at the edge that also advances rd_ptr past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, do_push} - {1'b0, do_pop};
      if (word_done && !do_push) overflow_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      fifo_data[wr_ptr] <= word_data;
      fifo_keep[wr_ptr] <= word_keep;
      fifo_last[wr_ptr] <= frame_end;
    end
  end

  assign bus.valid_out = !fifo_empty;
  assign bus.data_out  = fifo_empty ? 64'd0 : fifo_data[rd_ptr];
  assign bus.keep_out  = fifo_empty ? 8'd0  : fifo_keep[rd_ptr];
  assign bus.last_out  = fifo_empty ? 1'b0  : fifo_last[rd_ptr];
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_sobel_packer.sv
// Randomized and directed bench for sobel_packer (FRAME_PIXELS=20) against a
// queue-based word model; honours SOBEL_PACKER_BIN_EN like the design.
module tb_sobel_packer;
  localparam int FP = 20;
  localparam logic [7:0] THR = 8'd64;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  sobel_packer_if bus();

  sobel_packer #(.FRAME_PIXELS(FP), .THRESHOLD(THR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  word_t      exp_q[$];
  logic [7:0] part_q[$];
  int         frame_pos = 0;
  logic       exp_ovf = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    part_q.delete();
    frame_pos = 0;
    exp_ovf   = 1'b0;
  endtask

  // One clock of the reference: pop the head if the sink takes it, then
  // append the new word if there is room in the two-word queue.
  task automatic modelStep(input logic r, input logic v, input logic [7:0] d, input logic rdy);
    word_t w;
    logic  have_word;
    logic [7:0] px;
    if (r) begin
      modelReset();
      return;
    end
    have_word = 1'b0;
    if (v) begin
`ifdef SOBEL_PACKER_BIN_EN
      px = (d >= THR) ? 8'hFF : 8'h00;
`else
      px = d;
`endif
      part_q.push_back(px);
      if (part_q.size() == 8 || frame_pos == FP - 1) begin
        w.data = '0;
        w.keep = '0;
        foreach (part_q[i]) begin
          w.data[i*8 +: 8] = part_q[i];
          w.keep[i] = 1'b1;
        end
        w.last = (frame_pos == FP - 1);
        part_q.delete();
        have_word = 1'b1;
      end
      frame_pos = (frame_pos == FP - 1) ? 0 : frame_pos + 1;
    end
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    if (have_word) begin
      if (exp_q.size() < 2) exp_q.push_back(w);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic checkModel();
    checkOutput("valid_out", {63'd0, bus.valid_out}, {63'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      checkOutput("data_out", bus.data_out, exp_q[0].data);
      checkOutput("keep_out", {56'd0, bus.keep_out}, {56'd0, exp_q[0].keep});
      checkOutput("last_out", {63'd0, bus.last_out}, {63'd0, exp_q[0].last});
    end
    checkOutput("overflow", {63'd0, bus.overflow}, {63'd0, exp_ovf});
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    checkModel();
    rst          = r;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.ready_in = rdy;
    modelStep(r, v, d, rdy);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, {63'd0, bus.valid_out}, 64'd0);
    checkOutput({tag, "_data"}, bus.data_out, 64'd0);
    checkOutput({tag, "_keep"}, {56'd0, bus.keep_out}, 64'd0);
    checkOutput({tag, "_last"}, {63'd0, bus.last_out}, 64'd0);
    checkOutput({tag, "_ovf"}, {63'd0, bus.overflow}, 64'd0);
  endtask

  initial begin
    logic [31:0] bin_expect;
    rst          = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in  = 8'hAA;
    bus.ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkResetOutputs("reset");

    // Eight ascending pixels make one full word.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
    @(posedge clk); #1;
    checkOutput("first_word", bus.data_out, 64'h0807060504030201);
    checkOutput("first_keep", {56'd0, bus.keep_out}, 64'h00000000000000FF);

    // Rest of the 20-pixel frame: second full word, then a 4-byte last word.
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b1);
    @(posedge clk); #1;
    checkOutput("tail_keep", {56'd0, bus.keep_out}, 64'h000000000000000F);
    checkOutput("tail_last", {63'd0, bus.last_out}, 64'd1);

    // Stalled sink: two words queue, the third is dropped.
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
    @(posedge clk); #1;
    checkOutput("stall_ovf", {63'd0, bus.overflow}, 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);

    // Full FIFO relieved by a pop in the same cycle the third word completes.
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b1);
    @(posedge clk); #1;
    checkOutput("popfree_ovf", {63'd0, bus.overflow}, 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);

    // Threshold behaviour on the low four bytes of a word.
    applyStimulus(1'b0, 1'b1, 8'd63, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd64, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd200, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b1);
    @(posedge clk); #1;
`ifdef SOBEL_PACKER_BIN_EN
    bin_expect = 32'h00FFFF00;
`else
    bin_expect = 32'h00C8403F;
`endif
    checkOutput("bin_bytes", {32'd0, bus.data_out[31:0]}, {32'd0, bin_expect});

    // Reset with one word queued and five pixels pending.
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);
    @(posedge clk); #1;
    checkResetOutputs("midreset");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                    8'($urandom), $urandom_range(0, 9) < 6);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    checkModel();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sobel_packer.md
SOBEL_PACKER -- requirements
Module: sobel_packer

Interface
REQ-001 Parameter FRAME_PIXELS, default 307200: pixels per frame; legal range 1..2^24-1.
REQ-002 Parameter THRESHOLD, default 8'd64: binarization threshold, used only when SOBEL_PACKER_BIN_EN is defined.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  8  edge-magnitude pixel from sobel_filter data_out.
REQ-006 valid_in  input  1  data_in qualifier from sobel_filter valid_out; no backpressure upstream.
REQ-007 data_out  output  64  packed word; byte k holds the k-th pixel of the word.
REQ-008 keep_out  output  8  byte enables for data_out; bit k set = byte k valid.
REQ-009 last_out  output  1  word holds the final pixel of a frame.
REQ-010 valid_out  output  1  data_out/keep_out/last_out valid.
REQ-011 ready_in  input  1  downstream accepts a word when valid_out && ready_in.
REQ-012 overflow  output  1  sticky: at least one word dropped since reset.

Function
REQ-013 A pixel is accepted on every cycle with valid_in=1; there is no stall toward the upstream stage.
REQ-014 Accepted pixels are written into an assembly register at byte index byte_idx (0..7), first pixel of a word in byte 0.
REQ-015 A pixel counter pix_cnt counts accepted pixels 0..FRAME_PIXELS-1 and wraps to 0 after the last pixel of the frame.
REQ-016 A word is complete when byte_idx=7 or pix_cnt=FRAME_PIXELS-1 at acceptance; byte_idx returns to 0 on completion.
REQ-017 A complete word is pushed into a 2-entry output FIFO with keep = bytes written in that word, unwritten bytes zero, and last=1 iff it holds pixel FRAME_PIXELS-1.
REQ-018 Latency: the completing pixel accepted in cycle N is presented on the outputs in cycle N+1 when the FIFO was empty.
REQ-019 valid_out = FIFO non-empty; head entry is popped on valid_out && ready_in.
REQ-020 While valid_out=1 and ready_in=0, data_out, keep_out and last_out are held stable.
REQ-021 Push and pop in the same cycle are both performed; when the FIFO is full, a simultaneous pop frees the slot for the push.
REQ-022 A push into a full FIFO with no pop drops the word, sets overflow to 1 and does not disturb FIFO contents; pix_cnt and byte_idx still advance.
REQ-023 overflow stays 1 until reset.
REQ-024 valid_in=0 cycles leave byte_idx, pix_cnt and the assembly register unchanged; a partial word is held indefinitely until completed.
REQ-025 Words are emitted in acceptance order; no reordering, no duplication.

Reset
REQ-026 On rst=1 at a clock edge: valid_out=0, data_out=0, keep_out=0, last_out=0, overflow=0, FIFO empty, byte_idx=0, pix_cnt=0, assembly register=0.
REQ-027 Reset mid-word or mid-frame discards the partial word and all queued words; the first pixel accepted after reset is pixel 0 of a new frame.
REQ-028 valid_in is ignored in any cycle with rst=1.

Configuration
REQ-029 With macro SOBEL_PACKER_BIN_EN defined, each accepted pixel is stored as 8'hFF if data_in >= THRESHOLD, else 8'h00.
REQ-030 Without SOBEL_PACKER_BIN_EN, each pixel is stored unmodified and THRESHOLD has no effect.

Verification (FRAME_PIXELS=20, ready_in=1 unless stated)
REQ-031 Pixels 0x01..0x08 on consecutive cycles -> one cycle after the 8th: data_out=64'h0807060504030201, keep_out=8'hFF, last_out=0, valid_out high one cycle.
REQ-032 Full frame of 20 pixels -> three words, keep 8'hFF, 8'hFF, 8'h0F; last_out=1 only on the third; 21st pixel starts byte 0 of a new frame.
REQ-033 ready_in=0, 24 pixels streamed -> first two words queued and held stable, third dropped, overflow=1; ready_in=1 -> exactly two words delivered in order.
REQ-034 FIFO full, ready_in=1 in the cycle a third word completes -> no drop, overflow stays 0, all three words delivered in order.
REQ-035 rst asserted after 5 pixels of a word with one word queued -> valid_out=0 next cycle, FIFO empty; following 8 pixels form a fresh word starting at byte 0.
REQ-036 SOBEL_PACKER_BIN_EN defined, THRESHOLD=64, pixels 63,64,200,0,... -> bytes 00,FF,FF,00; macro undefined -> bytes 3F,40,C8,00.
